phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter: NCH, default 8, number of AFE channels; CHEN width and channel count.
REQ-002 Parameter: CHW, default 3, CHSEL width (clog2 NCH).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 HF_CLK  input  1  sequencer clock.
REQ-005 NRST  input  1  asynchronous active-low reset, released synchronously to HF_CLK.
REQ-006 ENSAMP  input  1  sampling enable, already synchronized to HF_CLK.
REQ-007 PHASE1DIV1  input  12  phase-1 tick divider; one tick = PHASE1DIV1+1 HF_CLK cycles.
REQ-008 PHASE1COUNT  input  4  phase-1 length in ticks, minus 1.
REQ-009 PHASE2COUNT  input  10  phase-2 length in HF_CLK cycles, minus 1.
REQ-010 CHEN  input  NCH  per-channel enable; bit i enables channel i.
REQ-011 PHASE1  output  1  high while in phase 1 (AFE settle).
REQ-012 PHASE2  output  1  high while in phase 2 (ADC convert).
REQ-013 CHSEL  output  CHW  channel currently being sequenced.
REQ-014 SAMPLE_STROBE  output  1  one-cycle pulse on the last PHASE2 cycle of each channel.
REQ-015 FRAME_DONE  output  1  one-cycle pulse coincident with SAMPLE_STROBE of the highest-index enabled channel.
REQ-016 BUSY  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, PH1, PH2; exactly one active.
REQ-018 IDLE->PH1 on the cycle after ENSAMP=1 and CHEN!=0 are sampled; CHSEL loads the lowest-index enabled channel.
REQ-019 On IDLE->PH1, PHASE1DIV1, PHASE1COUNT, PHASE2COUNT and CHEN are latched into shadow registers; the sequencer uses only shadows until it next returns to IDLE.
REQ-020 PH1 lasts exactly (PHASE1DIV1+1)*(PHASE1COUNT+1) cycles, with PHASE1=1 throughout; all-zero config gives 1 cycle.
REQ-021 PH2 lasts exactly PHASE2COUNT+1 cycles, with PHASE2=1 throughout; SAMPLE_STROBE=1 only on its last cycle, with CHSEL equal to the sampled channel.
REQ-022 After PH2 the FSM enters PH1 for the next enabled channel in ascending order; disabled channels are skipped with zero cycle cost.
REQ-023 Wrap: after the highest enabled channel, the next channel is the lowest enabled channel; FRAME_DONE pulses with that channel's strobe.
REQ-024 Single enabled channel: FRAME_DONE accompanies every strobe; CHSEL stays constant.
REQ-025 ENSAMP=0 sampled in PH1 or PH2: next cycle IDLE; no SAMPLE_STROBE or FRAME_DONE for the aborted channel; counters cleared.
REQ-026 ENSAMP=0 on the same cycle a strobe would fire: the strobe fires (registered outputs reflect that cycle's state), then the FSM goes to IDLE.
REQ-027 In IDLE: PHASE1=PHASE2=SAMPLE_STROBE=FRAME_DONE=BUSY=0; CHSEL holds its last value.
REQ-028 Tick divider counts 0..PHASE1DIV1 (12-bit) and reloads to 0 on each PH1 entry; the phase counters are 4-bit and 10-bit with no overflow past the shadow value.
REQ-029 All outputs are registered; PHASE1 and PHASE2 are never high simultaneously.

Reset
REQ-030 NRST low: FSM=IDLE; all counters, shadows and CHSEL=0; all outputs 0, immediately and asynchronously.
REQ-031 NRST asserted mid-PH1/PH2 aborts with no strobe; after release the FSM resumes only through REQ-018.

Structure
REQ-032 A shared package holds the state enum (IDLE, PH1, PH2) and width constants: DIV1_W=12, P1CNT_W=4, P2CNT_W=10, NCH, CHW.
REQ-033 One sub-module, phase_tick_div: 12-bit divider with enable and clear, producing a one-cycle tick every DIV+1 cycles.
REQ-034 The next-enabled-channel search (circular priority from CHSEL+1) is combinational inside phase_sequencer.

Verification
REQ-035 CHEN=8'h05, DIV1=1, P1COUNT=0, P2COUNT=2, ENSAMP=1 -> PH1 2 cycles, PH2 3 cycles; strobes at CHSEL=0 then 2, spaced 5 cycles apart; FRAME_DONE with the CHSEL=2 strobe.
REQ-036 CHEN=8'h80, all counts 0 -> 2-cycle period; every strobe carries CHSEL=7 and FRAME_DONE.
REQ-037 ENSAMP dropped on cycle 2 of a 4-cycle PH2 -> IDLE next cycle; no strobe; BUSY=0.
REQ-038 CHEN=0 with ENSAMP=1 -> remains IDLE; BUSY=0 indefinitely.
REQ-039 PHASE1COUNT changed 3->7 mid-frame -> PH1 length is unchanged until an IDLE pass and re-enable.
REQ-040 NRST pulsed low during PH1 -> all outputs 0 asynchronously; after release, sequencing restarts from the lowest enabled channel.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared state encoding and field widths for the AFE phase sequencer.
package phase_sequencer_pkg;

  localparam int unsigned DIV1_W  = 12;
  localparam int unsigned P1CNT_W = 4;
  localparam int unsigned P2CNT_W = 10;
  localparam int unsigned NCH     = 8;
  localparam int unsigned CHW     = 3;

  typedef enum logic [1:0] {
    IDLE,
    PH1,
    PH2
  } state_e;

endpackage

// File: rtl/phase_sequencer_if.sv
// Configuration inputs and phase/status outputs of the phase sequencer.
interface phase_sequencer_if #(
  parameter int unsigned NCH = phase_sequencer_pkg::NCH,
  parameter int unsigned CHW = phase_sequencer_pkg::CHW
);

  logic                                   ENSAMP;
  logic [phase_sequencer_pkg::DIV1_W-1:0]  PHASE1DIV1;
  logic [phase_sequencer_pkg::P1CNT_W-1:0] PHASE1COUNT;
  logic [phase_sequencer_pkg::P2CNT_W-1:0] PHASE2COUNT;
  logic [NCH-1:0]                          CHEN;

  logic                                   PHASE1;
  logic                                   PHASE2;
  logic [CHW-1:0]                          CHSEL;
  logic                                   SAMPLE_STROBE;
  logic                                   FRAME_DONE;
  logic                                   BUSY;

  modport master (
    output ENSAMP, PHASE1DIV1, PHASE1COUNT, PHASE2COUNT, CHEN,
    input  PHASE1, PHASE2, CHSEL, SAMPLE_STROBE, FRAME_DONE, BUSY
  );

  modport slave (
    input  ENSAMP, PHASE1DIV1, PHASE1COUNT, PHASE2COUNT, CHEN,
    output PHASE1, PHASE2, CHSEL, SAMPLE_STROBE, FRAME_DONE, BUSY
  );

endinterface

// File: rtl/phase_tick_div.sv
// Phase-1 tick divider: one-cycle tick every div+1 enabled cycles.
module phase_tick_div
  import phase_sequencer_pkg::*;
(
  input  logic              HF_CLK,
  input  logic              NRST,
  input  logic              en,
  input  logic              clr,
  input  logic [DIV1_W-1:0] div,
  output logic              tick
);

  logic [DIV1_W-1:0] cnt_q;

  assign tick = en && (cnt_q == div);

  always_ff @(posedge HF_CLK or negedge NRST) begin
    if (!NRST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Per-channel AFE settle (PH1) / ADC convert (PH2) sequencer over enabled channels.
module phase_sequencer #(
  parameter int unsigned NCH = phase_sequencer_pkg::NCH,
  parameter int unsigned CHW = phase_sequencer_pkg::CHW
) (
  input logic              HF_CLK,
  input logic              NRST,
  phase_sequencer_if.slave bus
);

  import phase_sequencer_pkg::*;

  state_e               state_q, state_d;
  logic [CHW-1:0]       chsel_q, chsel_d;
  logic [NCH-1:0]       chen_sh_q, chen_sh_d;
  logic [DIV1_W-1:0]    div_sh_q, div_sh_d;
  logic [P1CNT_W-1:0]   p1_sh_q, p1_sh_d;
  logic [P2CNT_W-1:0]   p2_sh_q, p2_sh_d;
  logic [P1CNT_W-1:0]   p1_cnt_q, p1_cnt_d;
  logic [P2CNT_W-1:0]   p2_cnt_q, p2_cnt_d;
  logic                 phase1_q, phase1_d;
  logic                 phase2_q, phase2_d;
  logic                 strobe_q, strobe_d;
  logic                 frame_q, frame_d;
  logic                 busy_q, busy_d;

  logic                 tick;
  logic [CHW-1:0]       next_ch, lowest_ch, idx;
  logic                 last_ch;

  phase_tick_div u_tick_div (
    .HF_CLK (HF_CLK),
    .NRST   (NRST),
    .en     (state_q == PH1),
    .clr    (state_q != PH1),
    .div    (div_sh_q),
    .tick   (tick)
  );

  // Circular search from chsel+1; the current channel is found last, so a single
  // enabled channel maps onto itself.
  always_comb begin
    next_ch = chsel_q;
    idx     = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = CHW'((int'(chsel_q) + i) % NCH);
      if (chen_sh_q[idx]) next_ch = idx;
    end
  end

  always_comb begin
    lowest_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.CHEN[i]) lowest_ch = CHW'(i);
    end
  end

  assign last_ch = ((chen_sh_q >> chsel_q) == NCH'(1));

  always_comb begin
    state_d   = state_q;
    chsel_d   = chsel_q;
    chen_sh_d = chen_sh_q;
    div_sh_d  = div_sh_q;
    p1_sh_d   = p1_sh_q;
    p2_sh_d   = p2_sh_q;
    p1_cnt_d  = '0;
    p2_cnt_d  = '0;
    phase1_d  = 1'b0;
    phase2_d  = 1'b0;
    strobe_d  = 1'b0;
    frame_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ENSAMP && (|bus.CHEN)) begin
          state_d   = PH1;
          chsel_d   = lowest_ch;
          chen_sh_d = bus.CHEN;
          div_sh_d  = bus.PHASE1DIV1;
          p1_sh_d   = bus.PHASE1COUNT;
          p2_sh_d   = bus.PHASE2COUNT;
          phase1_d  = 1'b1;
        end
      end
      PH1: begin
        if (!bus.ENSAMP) begin
          state_d = IDLE;
        end else if (tick && (p1_cnt_q == p1_sh_q)) begin
          state_d  = PH2;
          phase2_d = 1'b1;
          strobe_d = (p2_sh_q == '0);
          frame_d  = strobe_d && last_ch;
        end else begin
          phase1_d = 1'b1;
          p1_cnt_d = tick ? p1_cnt_q + 1'b1 : p1_cnt_q;
        end
      end
      PH2: begin
        if (!bus.ENSAMP) begin
          state_d = IDLE;
        end else if (p2_cnt_q == p2_sh_q) begin
          state_d  = PH1;
          chsel_d  = next_ch;
          phase1_d = 1'b1;
        end else begin
          p2_cnt_d = p2_cnt_q + 1'b1;
          phase2_d = 1'b1;
          // Strobe is registered, so flag it one cycle ahead of the last PH2 cycle.
          strobe_d = (p2_cnt_d == p2_sh_q);
          frame_d  = strobe_d && last_ch;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge HF_CLK or negedge NRST) begin
    if (!NRST) begin
      state_q   <= IDLE;
      chsel_q   <= '0;
      chen_sh_q <= '0;
      div_sh_q  <= '0;
      p1_sh_q   <= '0;
      p2_sh_q   <= '0;
      p1_cnt_q  <= '0;
      p2_cnt_q  <= '0;
      phase1_q  <= 1'b0;
      phase2_q  <= 1'b0;
      strobe_q  <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      chsel_q   <= chsel_d;
      chen_sh_q <= chen_sh_d;
      div_sh_q  <= div_sh_d;
      p1_sh_q   <= p1_sh_d;
      p2_sh_q   <= p2_sh_d;
      p1_cnt_q  <= p1_cnt_d;
      p2_cnt_q  <= p2_cnt_d;
      phase1_q  <= phase1_d;
      phase2_q  <= phase2_d;
      strobe_q  <= strobe_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.PHASE1        = phase1_q;
  assign bus.PHASE2        = phase2_q;
  assign bus.CHSEL         = chsel_q;
  assign bus.SAMPLE_STROBE = strobe_q;
  assign bus.FRAME_DONE    = frame_q;
  assign bus.BUSY          = busy_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer; expected strobes go to a queue checked by a monitor.
module tb_phase_sequencer;

  logic HF_CLK = 1'b0;
  logic NRST   = 1'b0;

  phase_sequencer_if #(.NCH(8), .CHW(3)) bus ();

  phase_sequencer #(.NCH(8), .CHW(3)) dut (
    .HF_CLK (HF_CLK),
    .NRST   (NRST),
    .bus    (bus)
  );

  always #5 HF_CLK = ~HF_CLK;

  typedef struct {
    logic [2:0] ch;
    logic       frame;
    int         gap;  // cycles since previous strobe, 0 = not checked
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  int   overlap  = 0;

  always @(posedge HF_CLK) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(negedge HF_CLK) begin : monitor
    exp_t e;
    if (bus.PHASE1 && bus.PHASE2) overlap++;
    if (NRST && bus.FRAME_DONE) check("frame_with_strobe", 32'(bus.SAMPLE_STROBE), 32'd1);
    if (NRST && bus.SAMPLE_STROBE) begin
      check("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_ch_frame", 32'({bus.CHSEL, bus.FRAME_DONE}), 32'({e.ch, e.frame}));
        if (e.gap != 0) check("strobe_gap", 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge HF_CLK);
    #1;
  endtask

  task automatic push(input logic [2:0] ch, input logic frame, input int gap);
    exp_t e;
    e.ch = ch; e.frame = frame; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic set_cfg(input logic [7:0] chen, input logic [11:0] div,
                         input logic [3:0] p1, input logic [9:0] p2);
    bus.CHEN        = chen;
    bus.PHASE1DIV1  = div;
    bus.PHASE1COUNT = p1;
    bus.PHASE2COUNT = p2;
  endtask

  // Waits (bounded) for the phase to go high, then counts its high cycles.
  task automatic run_len(input bit ph2, output int n);
    int t = 0;
    n = 0;
    while (!(ph2 ? bus.PHASE2 : bus.PHASE1) && t < 200) begin step(); t++; end
    while ((ph2 ? bus.PHASE2 : bus.PHASE1) && n < 5000) begin step(); n++; end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 500) begin step(); t++; end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.PHASE1, bus.PHASE2, bus.CHSEL, bus.SAMPLE_STROBE, bus.FRAME_DONE, bus.BUSY});
  endfunction

  initial begin : timeout
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int t;
    logic seen;
    bus.ENSAMP = 1'b0;
    set_cfg(8'h00, 12'd0, 4'd0, 10'd0);

    // Reset state
    step(); step();
    check("reset_outputs", outs(), 32'd0);
    NRST = 1'b1;
    step();

    // CHEN=0 never leaves IDLE
    bus.ENSAMP = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); seen |= bus.BUSY | bus.PHASE1; end
    check("chen0_idle", 32'(seen), 32'd0);
    bus.ENSAMP = 1'b0;
    step();

    // Two channels (0, 2): PH1 2 cycles, PH2 3 cycles, strobes 5 apart
    set_cfg(8'h05, 12'd1, 4'd0, 10'd2);
    push(3'd0, 1'b0, 0); push(3'd2, 1'b1, 5); push(3'd0, 1'b0, 5); push(3'd2, 1'b1, 5);
    bus.ENSAMP = 1'b1;
    run_len(1'b0, n); check("ph1_len_2ch", 32'(n), 32'd2);
    run_len(1'b1, n); check("ph2_len_2ch", 32'(n), 32'd3);
    drain("drain_2ch");
    bus.ENSAMP = 1'b0;
    step();
    check("idle_after_2ch", 32'(bus.BUSY), 32'd0);
    step();

    // Single channel 7, all counts zero: 2-cycle period, FRAME_DONE every strobe
    set_cfg(8'h80, 12'd0, 4'd0, 10'd0);
    push(3'd7, 1'b1, 0); push(3'd7, 1'b1, 2); push(3'd7, 1'b1, 2); push(3'd7, 1'b1, 2);
    bus.ENSAMP = 1'b1;
    run_len(1'b0, n); check("ph1_len_min", 32'(n), 32'd1);
    run_len(1'b1, n); check("ph2_len_min", 32'(n), 32'd1);
    drain("drain_1ch");
    bus.ENSAMP = 1'b0;
    step();
    check("idle_after_1ch", 32'(bus.BUSY), 32'd0);
    step();

    // Abort on cycle 2 of a 4-cycle PH2: no strobe
    set_cfg(8'h01, 12'd0, 4'd0, 10'd3);
    bus.ENSAMP = 1'b1;
    t = 0;
    while (!bus.PHASE2 && t < 100) begin step(); t++; end
    check("ph2_reached", 32'(bus.PHASE2), 32'd1);
    step();
    bus.ENSAMP = 1'b0;
    step();
    check("abort_outputs", 32'({bus.BUSY, bus.PHASE1, bus.PHASE2}), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("abort_stays_idle", 32'(bus.BUSY), 32'd0);

    // ENSAMP dropped in the strobe cycle: strobe still fires, then IDLE
    set_cfg(8'h02, 12'd0, 4'd0, 10'd1);
    push(3'd1, 1'b1, 0);
    bus.ENSAMP = 1'b1;
    t = 0;
    while (!bus.SAMPLE_STROBE && t < 100) begin step(); t++; end
    bus.ENSAMP = 1'b0;
    step();
    check("idle_after_last_strobe", 32'(bus.BUSY), 32'd0);
    drain("drain_strobe_abort");

    // PHASE1COUNT change mid-frame is ignored until IDLE and re-enable
    set_cfg(8'h03, 12'd0, 4'd3, 10'd0);
    push(3'd0, 1'b0, 0); push(3'd1, 1'b1, 5);
    bus.ENSAMP = 1'b1;
    run_len(1'b0, n); check("p1_len_before", 32'(n), 32'd4);
    bus.PHASE1COUNT = 4'd7;
    run_len(1'b1, n); check("ph2_len_shadow", 32'(n), 32'd1);
    run_len(1'b0, n); check("p1_len_midframe", 32'(n), 32'd4);
    bus.ENSAMP = 1'b0;
    step();
    push(3'd0, 1'b0, 0);
    bus.ENSAMP = 1'b1;
    run_len(1'b0, n); check("p1_len_after", 32'(n), 32'd8);
    bus.ENSAMP = 1'b0;
    step();
    drain("drain_shadow");

    // NRST mid-PH1: outputs clear asynchronously, restart from lowest channel
    set_cfg(8'h0C, 12'd3, 4'd1, 10'd0);
    bus.ENSAMP = 1'b1;
    t = 0;
    while (!bus.PHASE1 && t < 100) begin step(); t++; end
    step(); step();
    check("pre_reset_ph1", 32'({bus.PHASE1, bus.CHSEL}), 32'({1'b1, 3'd2}));
    NRST = 1'b0;
    #1;
    check("async_reset", outs(), 32'd0);
    step(); step();
    push(3'd2, 1'b0, 0); push(3'd3, 1'b1, 9);
    NRST = 1'b1;
    run_len(1'b0, n); check("p1_len_after_reset", 32'(n), 32'd8);
    drain("drain_reset");
    bus.ENSAMP = 1'b0;
    step(); step();

    check("phase_overlap", 32'(overlap), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
